serializer8_ctrl: RTL

SERIALIZER8_CTRL -- requirements
Module: serializer8_ctrl

---
 rtl/serializer_pkg.sv | 6 +
 rtl/bit_sel8.sv | 10 +
 rtl/serializer8_ctrl.sv | 65 ++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// serializer_pkg: state encoding and width constants shared by the serializer files.
package serializer_pkg;
    localparam int WORD_BITS = 8;
    localparam int CNT_W     = 16;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
endpackage

// File: rtl/bit_sel8.sv
// bit_sel8: combinational 8-to-1 selector presenting one bit of the held word.
module bit_sel8
    import serializer_pkg::*;
(
    input  logic [WORD_BITS-1:0] held_word,
    input  logic [2:0]           sel,
    output logic                 sout
);
    assign sout = held_word[sel];
endmodule

// File: rtl/serializer8_ctrl.sv
// serializer8_ctrl: 8-bit parallel-to-serial controller with a bit-rate strobe.
// Back-to-back words are accepted on the final bit, so no idle cycle separates them.
module serializer8_ctrl
    import serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 shift_en,
    output logic [2:0]           sel,
    output logic                 sout,
    output logic                 sout_valid,
    output logic                 last,
    output logic [CNT_W-1:0]     word_cnt
);
    state_e                 state_q, state_d;
    logic [2:0]             bcnt_q, bcnt_d;
    logic [WORD_BITS-1:0]   held_q, held_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic                   accept, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            held_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            held_q     <= held_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // A word finishes on the strobe that advances past bit 7.
    assign done   = (state_q == SHIFT) && shift_en && (bcnt_q == 3'd7);
    assign accept = din_valid && din_ready;

    always_comb begin
        state_d    = accept ? SHIFT : (done ? IDLE : state_q);
        bcnt_d     = accept ? 3'd0 : ((state_q == SHIFT && shift_en) ? bcnt_q + 3'd1 : bcnt_q);
        held_d     = accept ? din : held_q;
        word_cnt_d = done ? word_cnt_q + CNT_W'(1) : word_cnt_q;
    end

    always_comb begin
        din_ready  = !rst && ((state_q == IDLE) || done);
        sout_valid = (state_q == SHIFT);
        last       = (state_q == SHIFT) && (bcnt_q == 3'd7);
        sel        = LSB_FIRST ? bcnt_q : 3'd7 - bcnt_q;
    end

    assign word_cnt = word_cnt_q;

    bit_sel8 u_bit_sel8 (
        .held_word (held_q),
        .sel       (sel),
        .sout      (sout)
    );
endmodule
